gc_scheduler: RTL and testbench

Stop-the-world scheduler and RAM-port arbiter between the evaluator (Fetch) and the mark/sweep garbage collector. It watches heap occupancy and explicit collection requests, and waits for the evaluator to reach a safe point. It then stalls the evaluator, hands the single-port heap RAM to the GC, and returns ownership when the GC reports completion.

---
 rtl/lisp.sv | 5 +
 rtl/gc_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_gc_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lisp.sv
// Shared word and address widths for the lisp machine datapath.
package lisp;
  localparam int unsigned WORD_SIZE  = 32;
  localparam int unsigned ADDR_WIDTH = 16;
endpackage

// File: rtl/gc_scheduler.sv
// Stop-the-world GC scheduler and heap RAM arbiter between evaluator and collector.
// Optional GC_TIMEOUT_EN adds a watchdog that forces release and pulses gc_timeout.
module gc_scheduler
  import lisp::*;
#(
  parameter int unsigned GC_THRESHOLD = 6144
`ifdef GC_TIMEOUT_EN
  ,
  parameter int unsigned GC_TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  eval_safe,
  input  logic [ADDR_WIDTH-1:0] eval_addr,
  input  logic [WORD_SIZE-1:0]  eval_data_out,
  input  logic                  eval_rden,
  input  logic                  eval_wren,
  output logic [WORD_SIZE-1:0]  eval_data_in,
  output logic                  eval_stall,
  input  logic [ADDR_WIDTH-1:0] heap_top,
  input  logic [WORD_SIZE-1:0]  env_root,
  input  logic                  gc_req,
  output logic                  gc_en,
  output logic [WORD_SIZE-1:0]  gc_env_addr,
  output logic [ADDR_WIDTH-1:0] gc_max_addr,
  input  logic [ADDR_WIDTH-1:0] gc_addr,
  input  logic [WORD_SIZE-1:0]  gc_data_out,
  input  logic                  gc_rden,
  input  logic                  gc_wren,
  output logic [WORD_SIZE-1:0]  gc_data_in,
  input  logic                  gc_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_SIZE-1:0]  ram_data_out,
  output logic                  ram_rden,
  output logic                  ram_wren,
  input  logic [WORD_SIZE-1:0]  ram_data_in,
  output logic                  gc_active,
`ifdef GC_TIMEOUT_EN
  output logic                  gc_timeout,
`endif
  output logic [15:0]           gc_count
);

  localparam logic [ADDR_WIDTH-1:0] THRESH = ADDR_WIDTH'(GC_THRESHOLD);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PEND    = 3'd1,
    QUIESCE = 3'd2,
    GRANT   = 3'd3,
    GC      = 3'd4,
    RELEASE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_EVAL = 2'd1,
    OWN_GC   = 2'd2
  } owner_t;

  state_t state, next_state;
  owner_t owner_tag, owner_next;
  logic   armed;
  logic   trig;
  logic   tmo_hit;

  assign trig = gc_req | (armed & (heap_top >= THRESH));

`ifdef GC_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(GC_TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;

  assign tmo_hit = (state == GC) && (tmo_cnt == TMO_LAST);

  // Watchdog counts cycles spent in GC; cleared whenever the state is left.
  always_ff @(posedge clk) begin
    if (rst || state != GC) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
    if (rst) begin
      gc_timeout <= 1'b0;
    end else begin
      gc_timeout <= tmo_hit & ~gc_done;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (trig) next_state = PEND;
      PEND:    if (eval_safe) next_state = QUIESCE;
      QUIESCE: next_state = GRANT;
      GRANT:   next_state = GC;
      GC:      if (gc_done || tmo_hit) next_state = RELEASE;
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // RAM mux: owner chosen by registered state; write wins over read.
  always_comb begin
    ram_addr     = '0;
    ram_data_out = '0;
    ram_rden     = 1'b0;
    ram_wren     = 1'b0;
    owner_next   = OWN_NONE;
    if (!rst) begin
      unique case (state)
        IDLE, PEND: begin
          ram_addr     = eval_addr;
          ram_data_out = eval_data_out;
          ram_rden     = eval_rden & ~eval_wren;
          ram_wren     = eval_wren;
          owner_next   = OWN_EVAL;
        end
        GRANT, GC: begin
          ram_addr     = gc_addr;
          ram_data_out = gc_data_out;
          ram_rden     = gc_rden & ~gc_wren;
          ram_wren     = gc_wren;
          owner_next   = OWN_GC;
        end
        default: ;
      endcase
    end
  end

  // Read data goes back to whoever owned the port when the read was issued.
  assign eval_data_in = (owner_tag == OWN_EVAL) ? ram_data_in : '0;
  assign gc_data_in   = (owner_tag == OWN_GC)   ? ram_data_in : '0;

  // Registered control outputs, trigger arming and grant-time captures.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_tag   <= OWN_NONE;
      armed       <= 1'b1;
      gc_en       <= 1'b0;
      gc_active   <= 1'b0;
      eval_stall  <= 1'b0;
      gc_env_addr <= '0;
      gc_max_addr <= '0;
      gc_count    <= '0;
    end else begin
      owner_tag  <= owner_next;
      gc_en      <= (next_state == GRANT) || (next_state == GC);
      gc_active  <= (next_state == GRANT) || (next_state == GC);
      eval_stall <= (next_state != IDLE) && (next_state != PEND);
      if (state == GRANT) begin
        armed <= 1'b0;
      end else if (state == IDLE && heap_top < THRESH) begin
        armed <= 1'b1;
      end
      // Evaluator is stalled in QUIESCE, so env_root and heap_top are stable here.
      if (next_state == GRANT) begin
        gc_env_addr <= env_root;
        gc_max_addr <= heap_top;
      end
      if (state == GC && next_state == RELEASE && gc_count != 16'hFFFF) begin
        gc_count <= gc_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gc_scheduler.sv
// Self-checking bench for gc_scheduler with a synchronous heap RAM model and read scoreboards.
module tb_gc_scheduler;
  import lisp::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  eval_safe;
  logic [ADDR_WIDTH-1:0] eval_addr;
  logic [WORD_SIZE-1:0]  eval_data_out;
  logic                  eval_rden;
  logic                  eval_wren;
  logic [WORD_SIZE-1:0]  eval_data_in;
  logic                  eval_stall;
  logic [ADDR_WIDTH-1:0] heap_top;
  logic [WORD_SIZE-1:0]  env_root;
  logic                  gc_req;
  logic                  gc_en;
  logic [WORD_SIZE-1:0]  gc_env_addr;
  logic [ADDR_WIDTH-1:0] gc_max_addr;
  logic [ADDR_WIDTH-1:0] gc_addr;
  logic [WORD_SIZE-1:0]  gc_data_out;
  logic                  gc_rden;
  logic                  gc_wren;
  logic [WORD_SIZE-1:0]  gc_data_in;
  logic                  gc_done;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WORD_SIZE-1:0]  ram_data_out;
  logic                  ram_rden;
  logic                  ram_wren;
  logic [WORD_SIZE-1:0]  ram_data_in;
  logic                  gc_active;
  logic [15:0]           gc_count;
`ifdef GC_TIMEOUT_EN
  logic                  gc_timeout;
`endif

  int checks = 0;
  int errors = 0;

  logic [WORD_SIZE-1:0] mem [0:255];
  logic [WORD_SIZE-1:0] eval_q [$];
  logic [WORD_SIZE-1:0] gc_q [$];

`ifdef GC_TIMEOUT_EN
  gc_scheduler #(.GC_THRESHOLD(6144), .GC_TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .eval_safe(eval_safe), .eval_addr(eval_addr),
    .eval_data_out(eval_data_out), .eval_rden(eval_rden), .eval_wren(eval_wren),
    .eval_data_in(eval_data_in), .eval_stall(eval_stall), .heap_top(heap_top),
    .env_root(env_root), .gc_req(gc_req), .gc_en(gc_en), .gc_env_addr(gc_env_addr),
    .gc_max_addr(gc_max_addr), .gc_addr(gc_addr), .gc_data_out(gc_data_out),
    .gc_rden(gc_rden), .gc_wren(gc_wren), .gc_data_in(gc_data_in), .gc_done(gc_done),
    .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_rden(ram_rden),
    .ram_wren(ram_wren), .ram_data_in(ram_data_in), .gc_active(gc_active),
    .gc_timeout(gc_timeout), .gc_count(gc_count)
  );
`else
  gc_scheduler #(.GC_THRESHOLD(6144)) dut (
    .clk(clk), .rst(rst), .eval_safe(eval_safe), .eval_addr(eval_addr),
    .eval_data_out(eval_data_out), .eval_rden(eval_rden), .eval_wren(eval_wren),
    .eval_data_in(eval_data_in), .eval_stall(eval_stall), .heap_top(heap_top),
    .env_root(env_root), .gc_req(gc_req), .gc_en(gc_en), .gc_env_addr(gc_env_addr),
    .gc_max_addr(gc_max_addr), .gc_addr(gc_addr), .gc_data_out(gc_data_out),
    .gc_rden(gc_rden), .gc_wren(gc_wren), .gc_data_in(gc_data_in), .gc_done(gc_done),
    .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_rden(ram_rden),
    .ram_wren(ram_wren), .ram_data_in(ram_data_in), .gc_active(gc_active),
    .gc_count(gc_count)
  );
`endif

  always #5 clk = ~clk;

  // Synchronous single-port heap RAM: read data appears the cycle after rden.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr[7:0]] <= ram_data_out;
    if (ram_rden) ram_data_in <= mem[ram_addr[7:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gc_en(input int limit, output int n);
    n = 0;
    while (gc_en !== 1'b1 && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    eval_rden = 1'b1;
    step();
    step();
    checks++; if (gc_en !== 1'b0) begin errors++; $display("FAIL reset_gc_en: got %0b expected 0", gc_en); end
    checks++; if (gc_active !== 1'b0) begin errors++; $display("FAIL reset_gc_active: got %0b expected 0", gc_active); end
    checks++; if (eval_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", eval_stall); end
    checks++; if (gc_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", gc_count); end
    checks++; if (ram_rden !== 1'b0 || ram_addr !== '0) begin errors++; $display("FAIL reset_ram: got rden %0b addr %0h expected 0 0", ram_rden, ram_addr); end
    checks++; if (eval_data_in !== '0 || gc_data_in !== '0) begin errors++; $display("FAIL reset_data_in: got %0h %0h expected 0 0", eval_data_in, gc_data_in); end
    checks++; if (gc_env_addr !== '0 || gc_max_addr !== '0) begin errors++; $display("FAIL reset_capture: got %0h %0h expected 0 0", gc_env_addr, gc_max_addr); end
    eval_rden = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_auto_trigger_isolation();
    heap_top = 16'd6144;
    env_root = 32'h0000ABCD;
    eval_safe = 1'b1;
    step();  // PEND
    checks++; if (gc_en !== 1'b0 || eval_stall !== 1'b0) begin errors++; $display("FAIL pend_outputs: got en %0b stall %0b expected 0 0", gc_en, eval_stall); end
    step();  // QUIESCE
    checks++; if (eval_stall !== 1'b1 || gc_en !== 1'b0) begin errors++; $display("FAIL quiesce_outputs: got stall %0b en %0b expected 1 0", eval_stall, gc_en); end
    eval_rden = 1'b1; eval_addr = 16'd1;
    #1;
    checks++; if (ram_rden !== 1'b0) begin errors++; $display("FAIL quiesce_no_access: got %0b expected 0", ram_rden); end
    eval_rden = 1'b0;
    step();  // GRANT
    checks++; if (gc_en !== 1'b1 || gc_active !== 1'b1) begin errors++; $display("FAIL grant_latency: got en %0b active %0b expected 1 1", gc_en, gc_active); end
    checks++; if (gc_max_addr !== 16'd6144) begin errors++; $display("FAIL grant_max_addr: got %0d expected 6144", gc_max_addr); end
    checks++; if (gc_env_addr !== 32'h0000ABCD) begin errors++; $display("FAIL grant_env_addr: got %0h expected abcd", gc_env_addr); end
    gc_done = 1'b1;
    step();  // GC
    gc_done = 1'b0;
    checks++; if (gc_en !== 1'b1) begin errors++; $display("FAIL done_in_grant_ignored: got en %0b expected 1", gc_en); end
    heap_top = 16'd7000;
    gc_wren = 1'b1; gc_addr = 16'd7; gc_data_out = 32'd55;
    eval_wren = 1'b1; eval_addr = 16'd9; eval_data_out = 32'd99;
    #1;
    checks++; if (ram_wren !== 1'b1 || ram_addr !== 16'd7 || ram_data_out !== 32'd55) begin errors++; $display("FAIL gc_write_mux: got wren %0b addr %0d data %0d expected 1 7 55", ram_wren, ram_addr, ram_data_out); end
    gc_wren = 1'b0;
    #1;
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL eval_isolated: got %0b expected 0", ram_wren); end
    gc_done = 1'b1;
    step();  // RELEASE
    gc_done = 1'b0;
    checks++; if (gc_en !== 1'b0 || gc_count !== 16'd1 || eval_stall !== 1'b1) begin errors++; $display("FAIL release_outputs: got en %0b count %0d stall %0b expected 0 1 1", gc_en, gc_count, eval_stall); end
    #1;
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL release_idle_port: got %0b expected 0", ram_wren); end
    step();  // IDLE
    checks++; if (eval_stall !== 1'b0 || gc_active !== 1'b0) begin errors++; $display("FAIL resume_outputs: got stall %0b active %0b expected 0 0", eval_stall, gc_active); end
    #1;
    checks++; if (ram_wren !== 1'b1 || ram_addr !== 16'd9) begin errors++; $display("FAIL resume_access: got wren %0b addr %0d expected 1 9", ram_wren, ram_addr); end
    eval_wren = 1'b0;
  endtask

  task automatic test_rearm();
    int n;
    logic seen = 1'b0;
    repeat (12) begin
      step();
      if (gc_en !== 1'b0 || eval_stall !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL no_rearm_high_heap: got gc seen %0b expected 0", seen); end
    heap_top = 16'd100;
    step();
    heap_top = 16'd7000;
    wait_gc_en(8, n);
    checks++; if (n != 3) begin errors++; $display("FAIL rearm_second_gc: got %0d cycles expected 3", n); end
    step();  // GC
    gc_done = 1'b1;
    step();  // RELEASE
    gc_done = 1'b0;
    checks++; if (gc_count !== 16'd2) begin errors++; $display("FAIL rearm_count: got %0d expected 2", gc_count); end
    heap_top = 16'd0;
    step();  // IDLE
  endtask

  task automatic test_safe_point_read();
    logic [WORD_SIZE-1:0] exp;
    logic seen = 1'b0;
    eval_safe = 1'b0;
    gc_req = 1'b1;
    step();  // PEND
    gc_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        exp = eval_q.pop_front();
        checks++; if (eval_data_in !== exp) begin errors++; $display("FAIL pend_read_%0d: got %0h expected %0h", i, eval_data_in, exp); end
      end
      checks++; if (eval_stall !== 1'b0) begin errors++; $display("FAIL pend_stall_%0d: got %0b expected 0", i, eval_stall); end
      eval_rden = 1'b1; eval_addr = 16'(10 + i);
      eval_q.push_back(mem[8'(10 + i)]);
      #1;
      checks++; if (ram_rden !== 1'b1 || ram_addr !== 16'(10 + i)) begin errors++; $display("FAIL pend_pass_%0d: got rden %0b addr %0d expected 1 %0d", i, ram_rden, ram_addr, 10 + i); end
      step();
    end
    exp = eval_q.pop_front();
    checks++; if (eval_data_in !== exp) begin errors++; $display("FAIL pend_read_last: got %0h expected %0h", eval_data_in, exp); end
    eval_rden = 1'b1; eval_addr = 16'd5; eval_safe = 1'b1;
    eval_q.push_back(32'h1234);
    step();  // QUIESCE
    eval_rden = 1'b0;
    exp = eval_q.pop_front();
    checks++; if (eval_stall !== 1'b1) begin errors++; $display("FAIL safe_stall: got %0b expected 1", eval_stall); end
    checks++; if (eval_data_in !== exp || gc_data_in !== '0) begin errors++; $display("FAIL read_routing: got eval %0h gc %0h expected %0h 0", eval_data_in, gc_data_in, exp); end
    step();  // GRANT
    gc_req = 1'b1;
    step();  // GC
    gc_req = 1'b0;
    gc_rden = 1'b1; gc_addr = 16'd3; eval_rden = 1'b1; eval_addr = 16'd4;
    gc_q.push_back(mem[3]);
    #1;
    checks++; if (ram_rden !== 1'b1 || ram_addr !== 16'd3) begin errors++; $display("FAIL gc_read_mux: got rden %0b addr %0d expected 1 3", ram_rden, ram_addr); end
    step();
    eval_rden = 1'b0;
    exp = gc_q.pop_front();
    checks++; if (gc_data_in !== exp || eval_data_in !== '0) begin errors++; $display("FAIL gc_read_routing: got gc %0h eval %0h expected %0h 0", gc_data_in, eval_data_in, exp); end
    gc_rden = 1'b1; gc_wren = 1'b1; gc_addr = 16'd20; gc_data_out = 32'd77;
    #1;
    checks++; if (ram_rden !== 1'b0 || ram_wren !== 1'b1) begin errors++; $display("FAIL write_wins: got rden %0b wren %0b expected 0 1", ram_rden, ram_wren); end
    gc_rden = 1'b0; gc_wren = 1'b0; gc_done = 1'b1;
    step();  // RELEASE
    gc_done = 1'b0;
    step();  // IDLE
    repeat (8) begin
      step();
      if (gc_en !== 1'b0 || eval_stall !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || gc_count !== 16'd3) begin errors++; $display("FAIL req_not_queued: got seen %0b count %0d expected 0 3", seen, gc_count); end
  endtask

  task automatic test_reset_mid_gc();
    int n;
    logic [WORD_SIZE-1:0] exp;
    eval_safe = 1'b1;
    gc_req = 1'b1;
    step();
    gc_req = 1'b0;
    wait_gc_en(10, n);
    checks++; if (gc_en !== 1'b1) begin errors++; $display("FAIL midgc_reach: got en %0b after %0d cycles expected 1", gc_en, n); end
    step();  // GC
    rst = 1'b1;
    step();
    checks++; if (gc_en !== 1'b0 || eval_stall !== 1'b0 || gc_active !== 1'b0 || gc_count !== 16'd0) begin errors++; $display("FAIL midgc_reset: got en %0b stall %0b active %0b count %0d expected 0 0 0 0", gc_en, eval_stall, gc_active, gc_count); end
    rst = 1'b0;
    eval_rden = 1'b1; eval_addr = 16'd2;
    eval_q.push_back(mem[2]);
    #1;
    checks++; if (ram_rden !== 1'b1 || ram_addr !== 16'd2) begin errors++; $display("FAIL midgc_owner_eval: got rden %0b addr %0d expected 1 2", ram_rden, ram_addr); end
    step();
    eval_rden = 1'b0;
    exp = eval_q.pop_front();
    checks++; if (eval_data_in !== exp) begin errors++; $display("FAIL midgc_read: got %0h expected %0h", eval_data_in, exp); end
    heap_top = 16'd7000;
    wait_gc_en(10, n);
    checks++; if (n != 3) begin errors++; $display("FAIL armed_after_reset: got %0d cycles expected 3", n); end
    step();  // GC
    gc_done = 1'b1;
    step();  // RELEASE
    gc_done = 1'b0;
    heap_top = 16'd0;
    step();
    step();
  endtask

`ifdef GC_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    gc_req = 1'b1;
    step();
    gc_req = 1'b0;
    wait_gc_en(10, n);
    step();  // first GC cycle
    n = 0;
    while (gc_timeout !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++; if (n != 20) begin errors++; $display("FAIL timeout_latency: got %0d cycles expected 20", n); end
    checks++; if (gc_en !== 1'b0 || gc_count !== 16'd2) begin errors++; $display("FAIL timeout_release: got en %0b count %0d expected 0 2", gc_en, gc_count); end
    step();
    checks++; if (gc_timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %0b expected 0", gc_timeout); end
    step();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + 32'(i);
    mem[5] = 32'h1234;
    ram_data_in = '0;
    rst = 1'b1; eval_safe = 1'b0; eval_addr = '0; eval_data_out = '0;
    eval_rden = 1'b0; eval_wren = 1'b0; heap_top = '0; env_root = '0;
    gc_req = 1'b0; gc_addr = '0; gc_data_out = '0; gc_rden = 1'b0;
    gc_wren = 1'b0; gc_done = 1'b0;
    test_reset();
    test_auto_trigger_isolation();
    test_rearm();
    test_safe_point_read();
    test_reset_mid_gc();
`ifdef GC_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
